// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer in front of the fixed-latency FPU: holds operands
// stable for the op's latency, stalls the pipeline, then emits a one-cycle writeback.
module fpu_issue_ctrl #(
  parameter int unsigned width = 32,
  parameter int unsigned RD_W  = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [3:0]       issue_op,
  input  logic [2:0]       issue_func3,
  input  logic             issue_rs1_0,
  input  logic [width-1:0] issue_a,
  input  logic [width-1:0] issue_b,
  input  logic [RD_W-1:0]  issue_rd,
  input  logic             issue_rd_fp,
  input  logic             kill,
  input  logic [width-1:0] fpu_result,
  output logic             fpu_sel,
  output logic [width-1:0] fpu_dataA,
  output logic [width-1:0] fpu_dataB,
  output logic [3:0]       fpu_op,
  output logic [2:0]       fpu_func3,
  output logic             fpu_rs1_0,
  output logic             stall,
  output logic             wb_valid,
  output logic [width-1:0] wb_data,
  output logic [RD_W-1:0]  wb_rd,
  output logic             wb_fp
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  logic [4:0]      lat;
  logic [RD_W-1:0] rd_q;
  logic            fp_q;
  logic            accept;

  always_comb begin
    case (issue_op)
      4'd0, 4'd1: lat = 5'd7;
      4'd2:       lat = 5'd5;
      4'd3:       lat = 5'd6;
      4'd4:       lat = 5'd0;
      4'd5:       lat = 5'd1;
      4'd6:       lat = 5'd16;
      4'd7:       lat = 5'd1;
      4'd8, 4'd9: lat = 5'd6;
      default:    lat = 5'd0;
    endcase
  end

  assign accept = (state == IDLE) && issue_valid && !kill;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (kill) state_nxt = IDLE;
               else if (cnt == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Kill wins over completion, so the result is only captured when not killed.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt       <= '0;
      fpu_dataA <= '0;
      fpu_dataB <= '0;
      fpu_op    <= '0;
      fpu_func3 <= '0;
      fpu_rs1_0 <= 1'b0;
      rd_q      <= '0;
      fp_q      <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_fp     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt       <= lat;
          fpu_dataA <= issue_a;
          fpu_dataB <= issue_b;
          fpu_op    <= issue_op;
          fpu_func3 <= issue_func3;
          fpu_rs1_0 <= issue_rs1_0;
          rd_q      <= issue_rd;
          fp_q      <= issue_rd_fp;
        end
        BUSY: if (kill) begin
          cnt <= '0;
        end else if (cnt != 5'd0) begin
          cnt <= cnt - 5'd1;
        end else begin
          wb_data <= fpu_result;
          wb_rd   <= rd_q;
          wb_fp   <= fp_q;
        end
        default: ;
      endcase
    end
  end

  // Combinational outputs are gated by clear so they read 0 throughout reset.
  always_comb begin
    fpu_sel  = 1'b0;
    stall    = 1'b0;
    wb_valid = 1'b0;
    if (!clear) begin
      fpu_sel  = (state == BUSY);
      stall    = ((state == IDLE) && issue_valid) || (state == BUSY);
      wb_valid = (state == DONE) && !kill;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: timing reference model plus decoupled
// writeback monitor, directed scenarios then randomized ops.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [2:0]  issue_func3;
  logic        issue_rs1_0;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic        issue_rd_fp;
  logic        kill;
  logic [31:0] fpu_result;
  logic        fpu_sel;
  logic [31:0] fpu_dataA, fpu_dataB;
  logic [3:0]  fpu_op;
  logic [2:0]  fpu_func3;
  logic        fpu_rs1_0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_fp;

  fpu_issue_ctrl #(.width(32), .RD_W(5)) dut (
    .clock(clk), .clear(clear), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_func3(issue_func3), .issue_rs1_0(issue_rs1_0), .issue_a(issue_a),
    .issue_b(issue_b), .issue_rd(issue_rd), .issue_rd_fp(issue_rd_fp), .kill(kill),
    .fpu_result(fpu_result), .fpu_sel(fpu_sel), .fpu_dataA(fpu_dataA),
    .fpu_dataB(fpu_dataB), .fpu_op(fpu_op), .fpu_func3(fpu_func3),
    .fpu_rs1_0(fpu_rs1_0), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_fp(wb_fp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fp;
    int          cyc;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  lat_tab[16] = '{7, 7, 5, 6, 0, 1, 16, 1, 6, 6, 0, 0, 0, 0, 0, 0};

  // Reference state: one op in flight, accepted in cycle m_t, writes back in m_done.
  bit          m_active = 1'b0;
  int          m_done;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_r;

  function automatic logic [31:0] res_of(input int c);
    logic [31:0] cc;
    cc = c;
    return (cc * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_zero();
    chk("rst_dataA", fpu_dataA, 32'h0);
    chk("rst_dataB", fpu_dataB, 32'h0);
    chk("rst_op", 32'(fpu_op), 32'h0);
    chk("rst_func3", 32'(fpu_func3), 32'h0);
    chk("rst_rs1_0", 32'(fpu_rs1_0), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk("rst_wb_fp", 32'(wb_fp), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_fpu_sel", 32'(fpu_sel), 32'h0);
  endtask

  task automatic drive(input logic iv, input logic [3:0] op, input logic [2:0] f3,
                       input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic fp, input logic k);
    @(posedge clk);
    #1;
    cyc++;
    issue_valid = iv;  issue_op = op;  issue_func3 = f3;  issue_rs1_0 = r;
    issue_a = a;  issue_b = b;  issue_rd = rd;  issue_rd_fp = fp;  kill = k;
    fpu_result = res_of(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 4'($urandom), 3'($urandom), 1'b0, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0);
  endtask

  // EX holds the instruction through its writeback cycle; operands may change meanwhile.
  task automatic issue(input logic [3:0] op, input logic [2:0] f3, input logic r,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic fp, input int kill_at, input int clr_at);
    int n;
    n = lat_tab[op] + 3;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, op, f3, r, (i == 0) ? a : $urandom, (i == 0) ? b : $urandom, rd, fp,
            i == kill_at);
      if (i == clr_at) begin
        #2 clear = 1'b1;
        #1 check_zero();
      end
      if (i == kill_at || i == clr_at) break;
    end
  endtask

  always @(negedge clk) begin : model
    bit   idle_now;
    logic e_stall, e_sel, e_wbv;
    if (clear) begin
      chk("stall_rst", 32'(stall), 32'h0);
      chk("sel_rst", 32'(fpu_sel), 32'h0);
      chk("wbv_rst", 32'(wb_valid), 32'h0);
      m_active = 1'b0;
      exp_q.delete();
    end else begin
      idle_now = !m_active;
      e_stall  = idle_now ? issue_valid : (cyc < m_done);
      e_sel    = m_active && (cyc < m_done);
      e_wbv    = m_active && (cyc == m_done) && !kill;
      chk("stall", 32'(stall), 32'(e_stall));
      chk("fpu_sel", 32'(fpu_sel), 32'(e_sel));
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      if (e_sel) begin
        chk("hold_dataA", fpu_dataA, m_a);
        chk("hold_dataB", fpu_dataB, m_b);
        chk("hold_op", 32'(fpu_op), 32'(m_op));
        chk("hold_func3", 32'(fpu_func3), 32'(m_f3));
        chk("hold_rs1_0", 32'(fpu_rs1_0), 32'(m_r));
      end
      if (idle_now && issue_valid && !kill) begin
        wb_t e;
        m_active = 1'b1;
        m_done   = cyc + lat_tab[issue_op] + 2;
        m_a = issue_a;  m_b = issue_b;  m_op = issue_op;
        m_f3 = issue_func3;  m_r = issue_rs1_0;
        e.data = res_of(m_done - 1);
        e.rd   = issue_rd;
        e.fp   = issue_rd_fp;
        e.cyc  = m_done;
        exp_q.push_back(e);
      end else if (m_active && kill) begin
        m_active = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end else if (m_active && cyc == m_done) begin
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    wb_t e;
    if (!clear && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", 32'(wb_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_fp", 32'(wb_fp), 32'(e.fp));
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    clear = 1'b1;
    issue_valid = 1'b0;  issue_op = '0;  issue_func3 = '0;  issue_rs1_0 = 1'b0;
    issue_a = '0;  issue_b = '0;  issue_rd = '0;  issue_rd_fp = 1'b0;  kill = 1'b0;
    fpu_result = '0;
    idle(2);
    check_zero();
    clear = 1'b0;
    idle(1);

    issue(4'd0, 3'd0, 1'b0, 32'h3F800000, 32'h40000000, 5'd3, 1'b1, -1, -1);   // FADD
    issue(4'd4, 3'd0, 1'b0, 32'h3F800000, 32'h80000000, 5'd4, 1'b1, -1, -1);   // FSGNJ
    idle(1);
    issue(4'd6, 3'd0, 1'b0, 32'h41800000, 32'h0, 5'd5, 1'b1, -1, -1);          // FSQRT
    issue(4'd3, 3'd0, 1'b0, 32'h40000000, 32'h3F800000, 5'd6, 1'b1, 3, -1);    // FDIV killed
    idle(2);
    issue(4'd2, 3'd0, 1'b0, 32'h40000000, 32'h40400000, 5'd7, 1'b1, -1, 2);    // FMUL, reset
    idle(1);
    clear = 1'b0;
    idle(3);
    issue(4'd2, 3'd0, 1'b0, 32'h40000000, 32'h40400000, 5'd8, 1'b1, -1, -1);   // FMUL
    issue(4'd7, 3'd2, 1'b0, 32'h3F800000, 32'h3F800000, 5'd9, 1'b0, -1, -1);   // FEQ
    issue(4'd12, 3'd1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 5'd10, 1'b0, -1, -1); // unknown op
    issue(4'd5, 3'd0, 1'b0, 32'h1, 32'h2, 5'd11, 1'b1, 0, -1);                 // kill in IDLE
    idle(1);

    for (int t = 0; t < 150; t++) begin
      logic [3:0] op;
      int         ka;
      op = 4'($urandom_range(0, 15));
      ka = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat_tab[op] + 2) : -1;
      issue(op, 3'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
            1'($urandom), ka, -1);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
